cla5_bist_checker: RTL and testbench

- On-chip exhaustive self-test engine for the 5-bit carry-lookahead adder: the hardware counterpart of the stimulus benches.
- Generates every {cin, b, a} operand vector and drives the adder.
- Re-times the expected result to the adder latency, compares it against the adder's sum/cout, and reports error count, first failing vector and pass/fail.
- Sits beside the CLA at the top level; the CLA is its only client.

---
 rtl/cla_pkg.sv | 20 ++
 rtl/cla5_bist_delay.sv | 43 ++++
 rtl/cla5_bist_checker.sv | 172 +++++++++++++++++
 tb/tb_cla5_bist_checker.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the 5-bit CLA self-test engine.
//   bist_state_e : checker sequencing states
//   WIDTH_DEF    : default adder operand width
//   vec_width()  : width of one {cin, b, a} operand vector
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bist_state_e;

  localparam int WIDTH_DEF = 5;

  function automatic int vec_width(input int width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/cla5_bist_delay.sv
// Valid + vector shift register. It carries each driven operand vector
// forward so that it arrives at the comparator together with the adder
// result for that vector.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : stage-0 valid (high only while vectors are being driven)
//   in_vec     : vector currently presented to the adder
//   out_valid  : last stage valid
//   out_vec    : last stage vector
module cla5_bist_delay #(
  parameter int VW    = 11,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [VW-1:0] in_vec,
  output logic          out_valid,
  output logic [VW-1:0] out_vec
);

  logic          valid_q [DEPTH];
  logic [VW-1:0] vec_q   [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        vec_q[i]   <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      vec_q[0]   <= in_vec;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        vec_q[i]   <= vec_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_vec   = vec_q[DEPTH-1];

endmodule

// File: rtl/cla5_bist_checker.sv
// Exhaustive self-test engine for the carry-lookahead adder. Drives every
// {cin, b, a} vector once, re-times the vector to the adder latency, and
// compares the adder result with a + b + cin at full width.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : begin a test (sampled in IDLE or DONE)
//   dut_a/b/cin     : registered operands to the adder
//   dut_sum/cout    : adder result, valid DUT_LAT cycles after operands
//   busy/done/pass  : registered status, derived from the previous state
//   err_count       : saturating mismatch count
//   first_err_valid : a mismatch has been captured
//   first_err_vec   : {cin, b, a} of the first mismatch
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | one new vector per cycle, vector 0 first
// DRAIN | DUT_LAT cycles for the last results to reach the comparator
// DONE  | results held until the next start
module cla5_bist_checker
  import cla_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DUT_LAT   = 1,
  parameter int ERR_CNT_W = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [WIDTH-1:0]       dut_a,
  output logic [WIDTH-1:0]       dut_b,
  output logic                   dut_cin,
  input  logic [WIDTH-1:0]       dut_sum,
  input  logic                   dut_cout,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_CNT_W-1:0]   err_count,
  output logic                   first_err_valid,
  output logic [2*WIDTH:0]       first_err_vec
);

  localparam int VW    = vec_width(WIDTH);
  // One spare bit so the counter never wraps inside a run.
  localparam int CW    = VW + 1;
  localparam int LAT_W = $clog2(DUT_LAT + 1);
  localparam logic [CW-1:0]    VEC_LAST  = CW'((1 << VW) - 1);
  localparam logic [LAT_W-1:0] DRAIN_TC0 = LAT_W'(DUT_LAT - 1);

  bist_state_e state_q, state_d;
  logic            launch;
  logic [CW-1:0]   vec_q;
  logic [VW-1:0]   op_q;
  logic [LAT_W-1:0] drain_q;

  logic            cmp_valid;
  logic [VW-1:0]   cmp_vec;
  logic [WIDTH:0]  exp_result;
  logic            mismatch;

  logic [ERR_CNT_W-1:0] err_q;
  logic                 fev_valid_q;
  logic [VW-1:0]        fev_q;
  logic                 busy_q, done_q, pass_q;

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          launch  = 1'b1;
        end
      end
      RUN: begin
        if (vec_q == VEC_LAST) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_q == '0) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          launch  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      op_q    <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;

      if (launch)                vec_q <= '0;
      else if (state_q == RUN)   vec_q <= vec_q + 1'b1;

      // op_q always equals the low bits of vec_q while in RUN.
      if (state_d != RUN)        op_q <= '0;
      else if (launch)           op_q <= '0;
      else                       op_q <= VW'(vec_q + 1'b1);

      // Down-counter: loaded on DRAIN entry, DONE at terminal count zero.
      if (state_q == RUN && state_d == DRAIN) drain_q <= DRAIN_TC0;
      else if (state_q == DRAIN && drain_q != '0) drain_q <= drain_q - 1'b1;
    end
  end

  assign {dut_cin, dut_b, dut_a} = op_q;

  cla5_bist_delay #(
    .VW    (VW),
    .DEPTH (DUT_LAT)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (state_q == RUN),
    .in_vec    (op_q),
    .out_valid (cmp_valid),
    .out_vec   (cmp_vec)
  );

  // Golden result at WIDTH+1 bits so the carry-out is compared too.
  assign exp_result = {1'b0, cmp_vec[WIDTH-1:0]}
                    + {1'b0, cmp_vec[2*WIDTH-1:WIDTH]}
                    + {{WIDTH{1'b0}}, cmp_vec[VW-1]};
  assign mismatch   = cmp_valid && ({dut_cout, dut_sum} != exp_result);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q       <= '0;
      fev_valid_q <= 1'b0;
      fev_q       <= '0;
    end else if (launch) begin
      err_q       <= '0;
      fev_valid_q <= 1'b0;
      fev_q       <= '0;
    end else if (mismatch) begin
      if (err_q != '1) err_q <= err_q + 1'b1;
      if (!fev_valid_q) begin
        fev_valid_q <= 1'b1;
        fev_q       <= cmp_vec;
      end
    end
  end

  // Status follows the state one cycle later, so done and pass rise after
  // the final compare has landed in err_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      busy_q <= (state_q == RUN) || (state_q == DRAIN);
      done_q <= (state_q == DONE);
      pass_q <= (state_q == DONE) && (err_q == '0);
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_valid_q;
  assign first_err_vec   = fev_q;

endmodule

// File: tb/tb_cla5_bist_checker.sv
module tb_cla5_bist_checker;

  localparam int NI = 3;
  localparam int VN = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [NI-1:0]        start, busy, done, pass, fevv;
  logic [NI-1:0][10:0]  fev, drv;
  logic [NI-1:0][11:0]  errc;

  // Fault configuration per instance: 0 none, 1 stuck bit, 2 vector-set flip.
  int fmode [NI];
  int fbit  [NI];
  int fval  [NI];
  int fmod  [NI];
  int frem  [NI];
  int fmask [NI];

  int tests = 0;
  int fails = 0;

  function automatic logic [5:0] adder_out(input logic [10:0] v, input int i);
    logic [5:0] r;
    r = 6'(v[4:0]) + 6'(v[9:5]) + 6'(v[10]);
    case (fmode[i])
      1: r[fbit[i]] = fval[i][0];
      2: if (int'(v) % fmod[i] == frem[i]) r = r ^ 6'(fmask[i]);
      default: ;
    endcase
    return r;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int LAT = (gi == 1) ? 3 : 1;
    localparam int EW  = (gi == 2) ? 8 : 12;
    logic [4:0]    a, b, sum;
    logic          cin, cout;
    logic [EW-1:0] ec;
    logic [5:0]    pipe [LAT];

    cla5_bist_checker #(.WIDTH(5), .DUT_LAT(LAT), .ERR_CNT_W(EW)) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start[gi]),
      .dut_a           (a),
      .dut_b           (b),
      .dut_cin         (cin),
      .dut_sum         (sum),
      .dut_cout        (cout),
      .busy            (busy[gi]),
      .done            (done[gi]),
      .pass            (pass[gi]),
      .err_count       (ec),
      .first_err_valid (fevv[gi]),
      .first_err_vec   (fev[gi])
    );

    // Behavioural adder with LAT register stages and optional fault.
    always_ff @(posedge clk) begin
      pipe[0] <= adder_out({cin, b, a}, gi);
      for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
    end
    assign {cout, sum} = pipe[LAT-1];
    assign errc[gi]    = 12'(ec);
    assign drv[gi]     = {cin, b, a};
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk every vector, compare faulty adder with plain arithmetic.
  task automatic ref_run(input int i, input int ew, output int cnt, output int first,
                         output bit any);
    int good;
    cnt = 0; first = 0; any = 1'b0;
    for (int v = 0; v < VN; v++) begin
      good = (v & 31) + ((v >> 5) & 31) + ((v >> 10) & 1);
      if (int'(adder_out(11'(v), i)) != good) begin
        if (!any) begin any = 1'b1; first = v; end
        if (cnt < (1 << ew) - 1) cnt++;
      end
    end
  endtask

  task automatic run_and_check(input int i, input string tag, input bit hold_start);
    int lat, ew, n, probe, ecnt, efirst;
    bit eany;
    lat = (i == 1) ? 3 : 1;
    ew  = (i == 2) ? 8 : 12;
    n   = 0;
    ref_run(i, ew, ecnt, efirst, eany);
    probe = $urandom_range(2, 1990);
    @(negedge clk); start[i] = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start[i] = 1'b0;
    while (n < 2100) begin
      @(posedge clk); #1; n++;
      if (n == probe) begin
        check_eq({tag, "/vec"}, 32'(drv[i]), 32'(probe));
        check_eq({tag, "/busy_done"}, {30'd0, busy[i], done[i]}, 32'b10);
      end
      if (n == 2000) start[i] = 1'b0;
      if (done[i] && n > 1) break;
    end
    check_eq({tag, "/done_cycle"}, 32'(n), 32'(2049 + lat));
    check_eq({tag, "/err_count"}, 32'(errc[i]), 32'(ecnt));
    check_eq({tag, "/first_valid"}, 32'(fevv[i]), 32'(eany));
    check_eq({tag, "/first_vec"}, 32'(fev[i]), 32'(efirst));
    check_eq({tag, "/pass"}, 32'(pass[i]), 32'(ecnt == 0));
    check_eq({tag, "/busy_end"}, 32'(busy[i]), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check_eq({tag, "/hold"}, {19'd0, done[i], errc[i]}, {19'd0, 1'b1, 12'(ecnt)});
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("%s%0d/flags", tag, i),
               {28'd0, busy[i], done[i], pass[i], fevv[i]}, 32'd0);
      check_eq($sformatf("%s%0d/data", tag, i),
               {fev[i], errc[i], drv[i]}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = '0;
    for (int i = 0; i < NI; i++) begin
      fmode[i] = 0; fbit[i] = 0; fval[i] = 0; fmod[i] = 1; frem[i] = 0; fmask[i] = 1;
    end
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    run_and_check(0, "clean_lat1", 1'b0);

    fmode[0] = 1; fbit[0] = 0; fval[0] = 0;
    run_and_check(0, "sum0_sa0", 1'b0);
    check_eq("sum0_sa0/const", {9'd0, fev[0], errc[0]}, {9'd0, 11'h001, 12'd1024});

    fbit[0] = 5;
    run_and_check(0, "cout_sa0", 1'b0);
    check_eq("cout_sa0/const", {9'd0, fev[0], errc[0]}, {9'd0, 11'h03F, 12'd1024});

    fmode[2] = 1; fbit[2] = 0; fval[2] = 0;
    run_and_check(2, "sat8", 1'b0);
    check_eq("sat8/const", {9'd0, fev[2], errc[2]}, {9'd0, 11'h001, 12'd255});

    run_and_check(1, "clean_lat3", 1'b0);

    // Asynchronous reset in the middle of a run on the DUT_LAT=3 instance.
    @(negedge clk); start[1] = 1'b1;
    @(posedge clk); #1; start[1] = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check_eq("midrun/vec", 32'(drv[1]), 32'd100);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk); rst_n = 1'b1;
    run_and_check(1, "after_rst", 1'b0);

    // start held through RUN, then a back-to-back restart from DONE.
    fmode[0] = 2; fmod[0] = 37; frem[0] = 5; fmask[0] = 6;
    run_and_check(0, "hold_start", 1'b1);
    run_and_check(0, "restart", 1'b0);

    for (int k = 0; k < 4; k++) begin
      int i;
      i = $urandom_range(0, NI - 1);
      fmode[i] = $urandom_range(1, 2);
      fbit[i]  = $urandom_range(0, 5);
      fval[i]  = $urandom_range(0, 1);
      fmod[i]  = $urandom_range(1, 300);
      frem[i]  = $urandom_range(0, fmod[i] - 1);
      fmask[i] = $urandom_range(1, 63);
      run_and_check(i, $sformatf("rand%0d_i%0d", k, i), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
